// File: rtl/ram32_ctrl_pkg.sv
// Shared types and constants for the RAM32 Wishbone controller.
// Optional BIST support is enabled with the RAM32_CTRL_BIST_EN macro.
package ram32_ctrl_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    // Base of the BIST data pattern; the low bits carry the word index.
    localparam logic [31:0] BIST_PAT = 32'hA5A5_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        B_IDLE,
        B_WRITE,
        B_READ,
        B_RWAIT
    } bist_phase_t;

    function automatic logic [31:0] bist_pattern(input logic [7:0] idx);
        return BIST_PAT | {24'h0, idx};
    endfunction

endpackage

// File: rtl/ram32_wb_ctrl_if.sv
// Wishbone classic bus between the interconnect and the RAM32 controller.
interface ram32_wb_ctrl_if
    import ram32_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wb_sel_i;
    logic [ADDR_W+1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/ram32_bist_seq.sv
// Destructive march-free BIST for one RAM32: writes P(i) to every word,
// then reads each word back and compares. Used only with RAM32_CTRL_BIST_EN.
`ifdef RAM32_CTRL_BIST_EN
module ram32_bist_seq
    import ram32_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] ram_do,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_a,
    output logic [3:0]        ram_we,
    output logic [DATA_W-1:0] ram_di
);

    bist_phase_t       phase, phase_nxt;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic              chk;
    logic [DATA_W-1:0] expect_w;

    assign last     = (addr == '1);
    assign expect_w = DATA_W'(bist_pattern(8'(addr)));
    assign busy     = (phase != B_IDLE);
    // Read data is valid in READ for a combinational RAM, one cycle later otherwise.
    assign chk      = ((phase == B_READ) && (RD_LAT == 0)) || (phase == B_RWAIT);

    // Phase sequencing and RAM drive for the BIST pass.
    always_comb begin
        phase_nxt = phase;
        ram_en    = 1'b0;
        ram_a     = '0;
        ram_we    = '0;
        ram_di    = '0;
        case (phase)
            B_IDLE: begin
                if (start) phase_nxt = B_WRITE;
            end
            B_WRITE: begin
                ram_en = 1'b1;
                ram_a  = addr;
                ram_we = 4'hF;
                ram_di = expect_w;
                if (last) phase_nxt = B_READ;
            end
            B_READ: begin
                ram_en = 1'b1;
                ram_a  = addr;
                if (RD_LAT != 0) phase_nxt = B_RWAIT;
                else if (last)   phase_nxt = B_IDLE;
            end
            B_RWAIT: begin
                ram_a = addr;
                phase_nxt = last ? B_IDLE : B_READ;
            end
            default: phase_nxt = B_IDLE;
        endcase
    end

    // Phase register, word counter and sticky result flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase <= B_IDLE;
            addr  <= '0;
            done  <= 1'b0;
            fail  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            if ((phase == B_IDLE) && start) begin
                addr <= '0;
                done <= 1'b0;
                fail <= 1'b0;
            end
            if ((phase == B_WRITE) || ((phase == B_READ) && (RD_LAT == 0)) || (phase == B_RWAIT))
                addr <= addr + ADDR_W'(1);
            if (chk && (ram_do != expect_w)) fail <= 1'b1;
            if (chk && last) done <= 1'b1;
        end
    end

endmodule
`endif

// File: rtl/ram32_wb_ctrl.sv
// Wishbone classic slave driving one RAM32 32x32 single-port macro.
// Define RAM32_CTRL_BIST_EN to add the built-in self-test ports and logic.
module ram32_wb_ctrl
    import ram32_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned RD_LAT = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    ram32_wb_ctrl_if.slave    wb,
    output logic              ram_en_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [3:0]        ram_we_o,
    output logic [DATA_W-1:0] ram_di_o,
    input  logic [DATA_W-1:0] ram_do_i
`ifdef RAM32_CTRL_BIST_EN
    ,
    input  logic              bist_start_i,
    output logic              bist_busy_o,
    output logic              bist_done_o,
    output logic              bist_fail_o
`endif
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] hold_adr;
    logic              hold_we;
    logic [3:0]        hold_sel;
    logic [DATA_W-1:0] hold_dat;
    logic [DATA_W-1:0] rd_data;

    logic              core_en;
    logic [ADDR_W-1:0] core_a;
    logic [3:0]        core_we;
    logic [DATA_W-1:0] core_di;

    logic              wb_req;
    logic              req_block;
    logic              capture;
    logic              adr_unused;

    assign wb_req     = wb.wb_cyc_i & wb.wb_stb_i;
    assign capture    = (state == IDLE) & wb_req & ~req_block;
    // Byte-lane bits of the address are ignored: all accesses are word-aligned.
    assign adr_unused = ^wb.wb_adr_i[1:0];

    // Next state and RAM drive; the RAM is only touched from ACCESS.
    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        core_a    = '0;
        core_we   = '0;
        core_di   = '0;
        case (state)
            IDLE: begin
                if (capture) state_nxt = ACCESS;
            end
            ACCESS: begin
                core_en = 1'b1;
                core_a  = hold_adr;
                core_di = hold_dat;
                core_we = hold_we ? hold_sel : 4'h0;
                // Cycle abandoned: the RAM access above still completes, but no ack follows.
                if (!wb.wb_cyc_i)                  state_nxt = IDLE;
                else if (hold_we || (RD_LAT == 0)) state_nxt = ACK;
                else                               state_nxt = WAIT;
            end
            WAIT: begin
                core_a    = hold_adr;
                state_nxt = wb.wb_cyc_i ? ACK : IDLE;
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, request holding registers and registered read data.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= IDLE;
            hold_adr <= '0;
            hold_we  <= 1'b0;
            hold_sel <= '0;
            hold_dat <= '0;
            rd_data  <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                hold_adr <= wb.wb_adr_i[ADDR_W+1:2];
                hold_we  <= wb.wb_we_i;
                hold_sel <= wb.wb_sel_i;
                hold_dat <= wb.wb_dat_i;
            end
            if (((state == ACCESS) && !hold_we && (RD_LAT == 0)) || (state == WAIT))
                rd_data <= ram_do_i;
        end
    end

    assign wb.wb_dat_o = rd_data;
    assign wb.wb_ack_o = (state == ACK) & wb.wb_cyc_i;

`ifdef RAM32_CTRL_BIST_EN
    logic              bist_start;
    logic              bist_busy;
    logic              bist_en;
    logic [ADDR_W-1:0] bist_a;
    logic [3:0]        bist_we;
    logic [DATA_W-1:0] bist_di;

    // Start is taken only from IDLE and wins over a same-cycle bus request.
    assign bist_start = bist_start_i & (state == IDLE);
    assign req_block  = bist_start_i | bist_busy;

    ram32_bist_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_bist (
        .clk    (CLK),
        .rst_n  (RST_N),
        .start  (bist_start),
        .ram_do (ram_do_i),
        .busy   (bist_busy),
        .done   (bist_done_o),
        .fail   (bist_fail_o),
        .ram_en (bist_en),
        .ram_a  (bist_a),
        .ram_we (bist_we),
        .ram_di (bist_di)
    );

    assign bist_busy_o = bist_busy;
    assign ram_en_o    = bist_busy ? bist_en : core_en;
    assign ram_a_o     = bist_busy ? bist_a  : core_a;
    assign ram_we_o    = bist_busy ? bist_we : core_we;
    assign ram_di_o    = bist_busy ? bist_di : core_di;
`else
    assign req_block = 1'b0;
    assign ram_en_o  = core_en;
    assign ram_a_o   = core_a;
    assign ram_we_o  = core_we;
    assign ram_di_o  = core_di;
`endif

endmodule
